// File: rtl/mdu.sv
// Iterative RISC-V style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready request and result handshakes.
module mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a request transfers on a rising edge where in_valid && in_ready
  // && !flush; a result transfers on an edge where out_valid && out_ready.
  // flush wins over both and returns the unit to IDLE.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   md_q, md_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;

  // Operand decode at acceptance
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   bypass_res;

  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
    bypass_res = '0;
    if (div_zero) begin
      bypass_res = op[1] ? a : '1;
    end else if (div_ovf) begin
      bypass_res = op[1] ? '0 : a;
    end
  end

  // One iteration step. Multiply: hi accumulates, lo shifts out multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   fin_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, md_q};
    if (op_q[2]) begin
      // Borrow out of the trial subtraction means restore the shifted remainder
      if (div_diff[WIDTH]) begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -step_lo : step_lo;
    rem_s  = rneg_q ? -step_hi : step_hi;

    case (op_q)
      OP_MUL:                       fin_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fin_res = quo_s;
      default:                      fin_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    md_d    = md_q;
    res_d   = res_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = op;
          cnt_d  = '0;
          hi_d   = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (op[2]) begin
            md_d = mag_b;
            lo_d = mag_a;
          end else begin
            md_d = mag_a;
            lo_d = mag_b;
          end
          if (div_zero || div_ovf) begin
            res_d   = bypass_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          res_d   = fin_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      md_q    <= md_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = (state_q == DONE) ? res_q : '0;
  assign dbg_state_o = state_q;

endmodule
